wts_envelope_slot_scheduler: RTL and testbench
==============================================

WTS_ENVELOPE_SLOT_SCHEDULER -- requirements
Module: wts_envelope_slot_scheduler

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 enable  input  1  1 = slot sequencing runs; 0 = sequencer parked on the no-op slot.
REQ-004 req_valid  input  1  key-event request from the CPU register block.
REQ-005 req_ch  input  3  target channel: 0..4 = A..E; 5..7 = invalid.
REQ-006 req_cmd  input  2  event code: 01 = key_on, 10 = key_release, 11 = key_off, 00 = none.
REQ-007 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-008 active  output  3  slot index to the 5-channel envelope generator: 0..4 = channel, 5 = no operation.
REQ-009 frame_start  output  1  one-cycle pulse, high in every cycle where active == 0.
REQ-010 ch_x_key_on / ch_x_key_release / ch_x_key_off (x = a..e)  output  1 each  one-cycle event pulses to the envelope generator.
REQ-011 pending  output  5  bit n = 1 while channel n holds an undelivered event.

Function
REQ-012 Slot sequence SHALL be 0,1,2,3,4,5,0,... with one slot per clk while enable = 1; frame length is 6 cycles.
REQ-013 Clearing enable SHALL force active = 5 from the next cycle and hold it there; pending events are retained.
REQ-014 When enable rises, active SHALL be 0 in the following cycle; frame_start pulses in that cycle.
REQ-015 Per-channel pending register SHALL hold 2 bits (event code); 00 = empty.
REQ-016 An accepted request with a valid channel and nonzero cmd SHALL load the channel's pending register, visible on pending the next cycle.
REQ-017 An accepted request with req_ch > 4 or req_cmd = 00 SHALL be discarded with no state change.
REQ-018 A pending event for channel n SHALL be delivered as exactly one pulse on the matching ch_n output in the cycle where active == n, and pending[n] SHALL clear the next cycle.
REQ-019 All key outputs SHALL be registered: they are 0 in every cycle where active != their channel, and at most one of the three is high per channel per cycle.
REQ-020 Minimum latency is acceptance in cycle t to delivery in cycle t+1 (when active == n at t+1); maximum latency is t+6 while enable = 1.
REQ-021 If a request for channel n is accepted in the same cycle its old event is delivered, the old event SHALL be delivered and the new event SHALL remain pending for the next frame.
REQ-022 req_ready SHALL be combinational from req_ch and pending; it is always 1 for an invalid req_ch.
REQ-023 While active = 5, no key output SHALL assert.

Reset
REQ-024 While reset = 1, all outputs SHALL be registered to: active = 5, frame_start = 0, all key outputs = 0, pending = 0.
REQ-025 With enable = 1, the first cycle after reset release SHALL show active = 0.
REQ-026 Reset asserted mid-frame SHALL drop all pending events without emitting any key pulse.

Configuration
REQ-027 Macro WTS_KEY_EVENT_OVERWRITE_EN defined: req_ready is always 1, and a new request to a channel with a pending event overwrites it (last write wins, earlier event lost).
REQ-028 Macro WTS_KEY_EVENT_OVERWRITE_EN undefined: req_ready = 0 while pending[req_ch] = 1; in the REQ-021 same-cycle case, req_ready = 1.

Verification
REQ-029 Reset release with enable = 1 -> active sequence 0,1,2,3,4,5,0; frame_start high on cycles 1 and 7.
REQ-030 Request ch = 2, cmd = 01 accepted while active = 4 -> pending = 00100; ch_c_key_on pulses exactly in the next cycle with active = 2; pending = 0 the following cycle.
REQ-031 Requests ch = 1 cmd = 01, then ch = 1 cmd = 11, before slot 1 -> with the macro defined, only ch_b_key_off pulses; with the macro undefined, the second request stalls (req_ready = 0) until ch_b_key_on is delivered, then is accepted and delivers ch_b_key_off one frame later.
REQ-032 Request ch = 6 cmd = 01 and request ch = 0 cmd = 00 -> both accepted, pending stays 0, no key pulses.
REQ-033 Request ch = 3 cmd = 10 pending, enable dropped for 10 cycles -> active = 5 throughout with no pulses; after enable returns, active = 0 next cycle and ch_d_key_release pulses at active = 3.
REQ-034 Reset asserted one cycle before a scheduled delivery -> no pulse, pending = 0, active = 5 during reset.

Source files
------------

// File: rtl/wts_envelope_slot_scheduler.sv
// Envelope slot sequencer for five channels (A..E) plus a no-op slot. Per-channel key events are held until their slot arrives.
// Optional build macro WTS_KEY_EVENT_OVERWRITE_EN: always ready, and a newer request replaces an undelivered one.
module wts_envelope_slot_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       req_valid,
  input  logic [2:0] req_ch,
  input  logic [1:0] req_cmd,
  output logic       req_ready,
  output logic [2:0] active,
  output logic       frame_start,
  output logic       ch_a_key_on,
  output logic       ch_a_key_release,
  output logic       ch_a_key_off,
  output logic       ch_b_key_on,
  output logic       ch_b_key_release,
  output logic       ch_b_key_off,
  output logic       ch_c_key_on,
  output logic       ch_c_key_release,
  output logic       ch_c_key_off,
  output logic       ch_d_key_on,
  output logic       ch_d_key_release,
  output logic       ch_d_key_off,
  output logic       ch_e_key_on,
  output logic       ch_e_key_release,
  output logic       ch_e_key_off,
  output logic [4:0] pending
);

  localparam logic [2:0] SLOT_NOP    = 3'd5;
  localparam logic [1:0] CMD_NONE    = 2'b00;
  localparam logic [1:0] CMD_ON      = 2'b01;
  localparam logic [1:0] CMD_RELEASE = 2'b10;
  localparam logic [1:0] CMD_OFF     = 2'b11;

  logic [1:0] pend     [5];
  logic [1:0] pend_nxt [5];
  logic [2:0] active_nxt;
  logic [4:0] deliver;
  logic [4:0] key_on, key_rel, key_off;
  logic [4:0] on_nxt, rel_nxt, off_nxt;
  logic       busy;
  logic       accept;

  always_comb begin
    active_nxt = SLOT_NOP;
    if (enable)
      active_nxt = (active == SLOT_NOP) ? 3'd0 : active + 3'd1;

    busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      deliver[i] = (active == 3'(i)) && (pend[i] != CMD_NONE);
      pending[i] = (pend[i] != CMD_NONE);
      // A slot being drained this cycle frees its register, so it may take a new request.
      if ((req_ch == 3'(i)) && (pend[i] != CMD_NONE) && !deliver[i])
        busy = 1'b1;
    end

`ifdef WTS_KEY_EVENT_OVERWRITE_EN
    req_ready = 1'b1;
`else
    req_ready = !busy;
`endif

    accept = req_valid && req_ready && (req_cmd != CMD_NONE);

    for (int i = 0; i < 5; i++) begin
      pend_nxt[i] = deliver[i] ? CMD_NONE : pend[i];
      if (accept && (req_ch == 3'(i)))
        pend_nxt[i] = req_cmd;
      // Key pulses mirror the pending code of the slot entered next, so they line up with active.
      on_nxt[i]  = (active_nxt == 3'(i)) && (pend_nxt[i] == CMD_ON);
      rel_nxt[i] = (active_nxt == 3'(i)) && (pend_nxt[i] == CMD_RELEASE);
      off_nxt[i] = (active_nxt == 3'(i)) && (pend_nxt[i] == CMD_OFF);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active      <= SLOT_NOP;
      frame_start <= 1'b0;
      key_on      <= '0;
      key_rel     <= '0;
      key_off     <= '0;
      for (int i = 0; i < 5; i++)
        pend[i] <= CMD_NONE;
    end else begin
      active      <= active_nxt;
      frame_start <= (active_nxt == 3'd0);
      key_on      <= on_nxt;
      key_rel     <= rel_nxt;
      key_off     <= off_nxt;
      for (int i = 0; i < 5; i++)
        pend[i] <= pend_nxt[i];
    end
  end

  assign ch_a_key_on      = key_on[0];
  assign ch_a_key_release = key_rel[0];
  assign ch_a_key_off     = key_off[0];
  assign ch_b_key_on      = key_on[1];
  assign ch_b_key_release = key_rel[1];
  assign ch_b_key_off     = key_off[1];
  assign ch_c_key_on      = key_on[2];
  assign ch_c_key_release = key_rel[2];
  assign ch_c_key_off     = key_off[2];
  assign ch_d_key_on      = key_on[3];
  assign ch_d_key_release = key_rel[3];
  assign ch_d_key_off     = key_off[3];
  assign ch_e_key_on      = key_on[4];
  assign ch_e_key_release = key_rel[4];
  assign ch_e_key_off     = key_off[4];

endmodule

// File: tb/tb_wts_envelope_slot_scheduler.sv
// Directed bench for wts_envelope_slot_scheduler in its default build (overwrite macro undefined).
module tb_wts_envelope_slot_scheduler;

  logic       clk = 1'b0;
  logic       reset, enable, req_valid;
  logic [2:0] req_ch;
  logic [1:0] req_cmd;
  logic       req_ready, frame_start;
  logic [2:0] active;
  logic [4:0] pending;
  logic       a_on, a_rel, a_off, b_on, b_rel, b_off, c_on, c_rel, c_off;
  logic       d_on, d_rel, d_off, e_on, e_rel, e_off;
  logic [4:0] kon, krel, koff;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  assign kon  = {e_on, d_on, c_on, b_on, a_on};
  assign krel = {e_rel, d_rel, c_rel, b_rel, a_rel};
  assign koff = {e_off, d_off, c_off, b_off, a_off};

  wts_envelope_slot_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .req_valid(req_valid),
    .req_ch(req_ch), .req_cmd(req_cmd), .req_ready(req_ready),
    .active(active), .frame_start(frame_start),
    .ch_a_key_on(a_on), .ch_a_key_release(a_rel), .ch_a_key_off(a_off),
    .ch_b_key_on(b_on), .ch_b_key_release(b_rel), .ch_b_key_off(b_off),
    .ch_c_key_on(c_on), .ch_c_key_release(c_rel), .ch_c_key_off(c_off),
    .ch_d_key_on(d_on), .ch_d_key_release(d_rel), .ch_d_key_off(d_off),
    .ch_e_key_on(e_on), .ch_e_key_release(e_rel), .ch_e_key_off(e_off),
    .pending(pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full snapshot: active, frame_start, pending and all fifteen key lines.
  task automatic chk_all(input string tag, input logic [2:0] a, input logic fs,
                         input logic [4:0] p, input logic [4:0] on_e,
                         input logic [4:0] rel_e, input logic [4:0] off_e);
    chk({tag, ".active"}, 16'(active), 16'(a));
    chk({tag, ".frame_start"}, 16'(frame_start), 16'(fs));
    chk({tag, ".pending"}, 16'(pending), 16'(p));
    chk({tag, ".keys"}, {1'b0, kon, krel, koff}, {1'b0, on_e, rel_e, off_e});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; req_valid = 1'b0; req_ch = 3'd0; req_cmd = 2'b00;
    tick(); tick();
    chk_all("reset", 3'd5, 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Slot walk after reset release: 0..5 then 0 again.
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_all("seq", 3'((k - 1) % 6), ((k - 1) % 6) == 0, 5'b0, 5'b0, 5'b0, 5'b0);
    end

    // Channel C key_on requested in slot 4, delivered at slot 2 of the next frame.
    repeat (4) tick();
    chk("pre_c.active", 16'(active), 16'd4);
    req_valid = 1'b1; req_ch = 3'd2; req_cmd = 2'b01;
    chk("c.ready", 16'(req_ready), 16'd1);
    tick();
    req_valid = 1'b0;
    chk_all("c.load", 3'd5, 1'b0, 5'b00100, 5'b0, 5'b0, 5'b0);
    tick(); tick(); tick();
    chk_all("c.deliver", 3'd2, 1'b0, 5'b00100, 5'b00100, 5'b0, 5'b0);
    tick();
    chk_all("c.clear", 3'd3, 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Channel B: key_on then key_off; second request stalls until the first drains.
    req_valid = 1'b1; req_ch = 3'd1; req_cmd = 2'b01;
    tick();
    chk_all("b.load", 3'd4, 1'b0, 5'b00010, 5'b0, 5'b0, 5'b0);
    req_cmd = 2'b11;
    chk("b.stall4", 16'(req_ready), 16'd0);
    tick();
    chk("b.stall5", 16'(req_ready), 16'd0);
    chk("b.hold", 16'(pending), 16'b00010);
    tick();
    chk("b.stall0", 16'(req_ready), 16'd0);
    tick();
    chk_all("b.on", 3'd1, 1'b0, 5'b00010, 5'b00010, 5'b0, 5'b0);
    chk("b.ready_same", 16'(req_ready), 16'd1);
    tick();
    req_valid = 1'b0;
    chk_all("b.requeued", 3'd2, 1'b0, 5'b00010, 5'b0, 5'b0, 5'b0);
    repeat (5) tick();
    chk_all("b.off", 3'd1, 1'b0, 5'b00010, 5'b0, 5'b0, 5'b00010);
    tick();
    chk_all("b.clear", 3'd2, 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Discarded requests: invalid channel and null command.
    req_valid = 1'b1; req_ch = 3'd6; req_cmd = 2'b01;
    chk("inv.ready", 16'(req_ready), 16'd1);
    tick();
    req_ch = 3'd0; req_cmd = 2'b00;
    chk("nul.ready", 16'(req_ready), 16'd1);
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("discard.pending", 16'(pending), 16'd0);
      chk("discard.keys", {1'b0, kon, krel, koff}, 16'd0);
      tick();
    end
    chk("pre_d.active", 16'(active), 16'd4);

    // Channel D release held across a 10-cycle enable gap.
    req_valid = 1'b1; req_ch = 3'd3; req_cmd = 2'b10;
    tick();
    req_valid = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_all("park", 3'd5, 1'b0, 5'b01000, 5'b0, 5'b0, 5'b0);
    end
    enable = 1'b1;
    tick();
    chk_all("resume", 3'd0, 1'b1, 5'b01000, 5'b0, 5'b0, 5'b0);
    repeat (3) tick();
    chk_all("d.rel", 3'd3, 1'b0, 5'b01000, 5'b0, 5'b01000, 5'b0);
    tick();
    chk_all("d.clear", 3'd4, 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    // Reset one cycle before channel A delivery drops the event silently.
    req_valid = 1'b1; req_ch = 3'd0; req_cmd = 2'b11;
    tick();
    req_valid = 1'b0;
    chk("a.load", 16'(pending), 16'b00001);
    reset = 1'b1;
    tick();
    chk_all("a.reset", 3'd5, 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    reset = 1'b0;
    tick();
    chk_all("a.after", 3'd0, 1'b1, 5'b0, 5'b0, 5'b0, 5'b0);

    // Minimum latency: accepted in slot 0, delivered in slot 1 of the next cycle.
    req_valid = 1'b1; req_ch = 3'd1; req_cmd = 2'b10;
    tick();
    req_valid = 1'b0;
    chk_all("minlat", 3'd1, 1'b0, 5'b00010, 5'b0, 5'b00010, 5'b0);
    tick();
    chk_all("minlat.clear", 3'd2, 1'b0, 5'b0, 5'b0, 5'b0, 5'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
